// File: rtl/udma_wrr_arbiter.sv
// udma_wrr_arbiter: weighted round-robin arbiter for the uDMA TX read path.
// Shares the L2 request port between N requesters. The turn owner keeps the
// grant for up to cfg_weight accepted grants (0 counts as 1), then ownership
// rotates. grant_ack_i (request FIFO ready) qualifies a grant as accepted.
// Optional build macro UDMA_WRR_HIPRIO_EN adds hiprio_i: while any
// high-priority request is pending, arbitration runs on that subset only.
module udma_wrr_arbiter #(
  parameter int N        = 10,
  parameter int S        = 4,
  parameter int WEIGHT_W = 4
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [N-1:0]                 req_i,
  input  logic [N-1:0][WEIGHT_W-1:0]   cfg_weight_i,
  input  logic                         grant_ack_i,
`ifdef UDMA_WRR_HIPRIO_EN
  input  logic [N-1:0]                 hiprio_i,
`endif
  output logic [N-1:0]                 grant_o,
  output logic [S-1:0]                 grant_idx_o,
  output logic                         anyGrant_o,
  output logic [S-1:0]                 cur_ptr_o
);

  localparam logic [S-1:0] LAST_IDX = S'(N - 1);

  logic [S-1:0]        r_ptr_q, r_ptr_d;
  logic [WEIGHT_W-1:0] r_cnt_q, r_cnt_d;

  logic [N-1:0]        req_eff;
  logic                keep;
  logic                found;
  logic [S-1:0]        sel;
  logic [WEIGHT_W-1:0] sel_weight;
  int                  cand;

`ifdef UDMA_WRR_HIPRIO_EN
  logic [N-1:0] hi_req;
  assign hi_req  = req_i & hiprio_i;
  // Low-priority requesters are invisible while any high-priority one waits.
  assign req_eff = (|hi_req) ? hi_req : req_i;
`else
  assign req_eff = req_i;
`endif

  // Selection: keep the owner while it has credit, else scan from owner+1
  // with the owner itself checked last (a lone requester is re-selected).
  always_comb begin
    keep  = req_eff[r_ptr_q] && (r_cnt_q != '0);
    found = 1'b0;
    sel   = '0;
    cand  = 0;
    if (keep) begin
      found = 1'b1;
      sel   = r_ptr_q;
    end else begin
      for (int k = 1; k <= N; k++) begin
        // r_ptr_q is always < N, so one subtraction gives an exact wrap.
        cand = int'(r_ptr_q) + k;
        if (cand >= N) cand = cand - N;
        if (!found && req_eff[cand]) begin
          found = 1'b1;
          sel   = S'(cand);
        end
      end
    end
  end

  // Zero-latency one-hot grant and status outputs.
  always_comb begin
    grant_o = '0;
    if (found) grant_o[sel] = 1'b1;
    grant_idx_o = found ? sel : '0;
    anyGrant_o  = |req_i;
    cur_ptr_o   = r_ptr_q;
  end

  // Turn bookkeeping: consume credit on keep, load a fresh turn otherwise.
  always_comb begin
    r_ptr_d    = r_ptr_q;
    r_cnt_d    = r_cnt_q;
    sel_weight = cfg_weight_i[sel];
    if (grant_ack_i && anyGrant_o) begin
      if (keep) begin
        r_cnt_d = r_cnt_q - WEIGHT_W'(1);
      end else begin
        r_ptr_d = sel;
        // Weight 0 behaves as 1, i.e. no extra grants.
        r_cnt_d = (sel_weight == '0) ? '0 : sel_weight - WEIGHT_W'(1);
      end
    end
  end

  // State registers; reset parks the pointer on N-1 so requester 0 wins first.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ptr_q <= LAST_IDX;
      r_cnt_q <= '0;
    end else begin
      r_ptr_q <= r_ptr_d;
      r_cnt_q <= r_cnt_d;
    end
  end

endmodule
